// File: rtl/assoc_data_cache.sv
// 2-way set-associative write-back/write-allocate data cache with true-LRU and saturating hit/miss counters.
// Read hits return data combinationally with no stall; misses stall the CPU via BUSYWAIT until the fill completes.
module assoc_data_cache #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int WPB     = 4,
  parameter int SETS    = 4,
  parameter int COUNT_W = 16
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           READ,
  input  logic                           WRITE,
  input  logic [ADDR_W-1:0]              ADDRESS,
  input  logic [DATA_W-1:0]              WRITEDATA,
  output logic [DATA_W-1:0]              READDATA,
  output logic                           BUSYWAIT,
  output logic                           MEM_READ,
  output logic                           MEM_WRITE,
  output logic [ADDR_W-$clog2(WPB)-1:0]  MEM_ADDRESS,
  output logic [DATA_W*WPB-1:0]          MEM_WRITEDATA,
  input  logic [DATA_W*WPB-1:0]          MEM_READDATA,
  input  logic                           MEM_BUSYWAIT,
  output logic [COUNT_W-1:0]             HIT_COUNT,
  output logic [COUNT_W-1:0]             MISS_COUNT
);

  localparam int OFF_W = $clog2(WPB);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = DATA_W * WPB;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
  state_t state;

  logic [BLK_W-1:0] data_mem [2][SETS];
  logic [TAG_W-1:0] tag_mem  [2][SETS];
  logic [1:0]       valid_q  [SETS];
  logic [1:0]       dirty_q  [SETS];
  logic [SETS-1:0]  lru_q;
  logic             vic_way;
  logic             first_cyc;
  logic             fill_pend;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic             req;
  logic             hit;
  logic             hit_way;
  logic             hit_fire;
  logic             victim;
  logic [1:0]       way_hit;
  logic [BLK_W-1:0] hit_blk;

  assign tag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign idx = ADDRESS[OFF_W +: IDX_W];
  assign off = ADDRESS[OFF_W-1:0];

  always_comb begin
    req        = READ | WRITE;
    way_hit[0] = valid_q[idx][0] && (tag_mem[0][idx] == tag);
    way_hit[1] = valid_q[idx][1] && (tag_mem[1][idx] == tag);
    hit        = req && (way_hit != 2'b00);
    hit_way    = way_hit[1];
    hit_blk    = data_mem[hit_way][idx];
    if (!valid_q[idx][0])      victim = 1'b0;
    else if (!valid_q[idx][1]) victim = 1'b1;
    else                       victim = lru_q[idx];
  end

  assign hit_fire = (state == IDLE) && hit;
  assign BUSYWAIT = (state != IDLE) || (req && !hit);
  // A simultaneous READ and WRITE is a store, so no load data is presented.
  assign READDATA = (hit && READ && !WRITE) ? hit_blk[int'(off)*DATA_W +: DATA_W] : '0;

  // Data and tag arrays carry no reset; valid bits gate their use.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      data_mem[vic_way][idx] <= MEM_READDATA;
      tag_mem[vic_way][idx]  <= tag;
    end else if (hit_fire && WRITE) begin
      data_mem[hit_way][idx][int'(off)*DATA_W +: DATA_W] <= WRITEDATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        dirty_q[s] <= 2'b00;
      end
      lru_q         <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      vic_way       <= 1'b0;
      first_cyc     <= 1'b0;
      fill_pend     <= 1'b0;
      HIT_COUNT     <= '0;
      MISS_COUNT    <= '0;
    end else begin
      if (hit_fire) begin
        lru_q[idx] <= ~hit_way;
        fill_pend  <= 1'b0;
        // The hit that retires a miss is part of that miss, not a new hit.
        if (!fill_pend && HIT_COUNT != '1) HIT_COUNT <= HIT_COUNT + 1'b1;
        if (WRITE) dirty_q[idx][hit_way] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (req && !hit) begin
            if (MISS_COUNT != '1) MISS_COUNT <= MISS_COUNT + 1'b1;
            vic_way   <= victim;
            first_cyc <= 1'b1;
            if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
              state         <= WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {tag_mem[victim][idx], idx};
              MEM_WRITEDATA <= data_mem[victim][idx];
            end else begin
              state       <= FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {tag, idx};
            end
          end
        end
        WRITEBACK: begin
          if (first_cyc) begin
            first_cyc <= 1'b0;
          end else if (!MEM_BUSYWAIT) begin
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {tag, idx};
            first_cyc   <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (first_cyc) begin
            first_cyc <= 1'b0;
          end else if (!MEM_BUSYWAIT) begin
            MEM_READ <= 1'b0;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          valid_q[idx][vic_way] <= 1'b1;
          dirty_q[idx][vic_way] <= 1'b0;
          fill_pend             <= 1'b1;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_data_cache.sv
// Directed scoreboard bench for assoc_data_cache: CPU loads and memory block transfers are
// checked by monitors against expectations queued by the stimulus.
module tb_assoc_data_cache;

  localparam int ADDR_W = 8, DATA_W = 8, WPB = 4, SETS = 4, COUNT_W = 4;

  logic        clk;
  logic        rst_n;
  logic        rd, wr;
  logic [7:0]  addr, wdata, readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic [3:0]  hit_count, miss_count;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] dat;
  } mem_op_t;

  mem_op_t    mem_q[$];
  logic [7:0] rd_q[$];

  assoc_data_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WPB(WPB), .SETS(SETS), .COUNT_W(COUNT_W)) dut (
    .CLK(clk), .RESET(rst_n), .READ(rd), .WRITE(wr), .ADDRESS(addr), .WRITEDATA(wdata),
    .READDATA(readdata), .BUSYWAIT(busywait), .MEM_READ(mem_read), .MEM_WRITE(mem_write),
    .MEM_ADDRESS(mem_address), .MEM_WRITEDATA(mem_writedata), .MEM_READDATA(mem_readdata),
    .MEM_BUSYWAIT(mem_busywait), .HIT_COUNT(hit_count), .MISS_COUNT(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block memory: each transfer completes on the third posedge of its strobe.
  logic [31:0] mem [64];
  logic [1:0]  lat;
  logic [31:0] rdata;
  assign mem_busywait = (mem_read || mem_write) && (lat != 2'd2);
  assign mem_readdata = rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat <= 2'd0;
    end else if (mem_read || mem_write) begin
      if (lat == 2'd2) begin
        lat <= 2'd0;
        if (mem_write) mem[mem_address] = mem_writedata;
        else           rdata <= mem[mem_address];
      end else begin
        lat <= lat + 2'd1;
      end
    end else begin
      lat <= 2'd0;
    end
  end

  // Load monitor: a read completes at the negedge where BUSYWAIT is low.
  always @(negedge clk) begin
    if (rst_n && rd && !wr && !busywait) begin
      checks++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL load_unexpected addr=%h got=%h required=none", addr, readdata);
      end else begin
        automatic logic [7:0] exp = rd_q.pop_front();
        if (readdata !== exp) begin
          fails++;
          $display("FAIL load addr=%h got=%h required=%h", addr, readdata, exp);
        end
      end
    end
  end

  // Memory monitor: each new strobe is one block transfer.
  logic prev_r = 1'b0, prev_w = 1'b0;
  always @(negedge clk) begin
    if (mem_read && mem_write) begin
      checks++;
      fails++;
      $display("FAIL strobe_overlap got=both required=exclusive");
    end
    if ((mem_read && !prev_r) || (mem_write && !prev_w)) begin
      checks++;
      if (mem_q.size() == 0) begin
        fails++;
        $display("FAIL mem_unexpected wr=%0d addr=%h got=op required=none", mem_write, mem_address);
      end else begin
        automatic mem_op_t e = mem_q.pop_front();
        if (mem_write !== e.wr || mem_address !== e.addr || (e.wr && mem_writedata !== e.dat)) begin
          fails++;
          $display("FAIL mem_op got wr=%0d addr=%h dat=%h required wr=%0d addr=%h dat=%h",
                   mem_write, mem_address, mem_writedata, e.wr, e.addr, e.dat);
        end
      end
    end
    prev_r <= mem_read;
    prev_w <= mem_write;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic mem_init();
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD0000 | 32'(i);
    mem[0] = 32'h44332211;
    mem[4] = 32'h88776655;
    mem[8] = 32'hCCBBAA99;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    mem_init();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cpu_op(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic exp_hit, input string name);
    int  stalls;
    bit  done;
    @(posedge clk);
    #1;
    rd = r; wr = w; addr = a; wdata = d;
    stalls = 0;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!busywait) done = 1;
      else stalls++;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL %s timeout got=busy required=done", name);
    end else if (exp_hit ? (stalls != 0) : (stalls == 0)) begin
      fails++;
      $display("FAIL %s stall got=%0d cycles required=%s", name, stalls, exp_hit ? "0" : "nonzero");
    end
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic rd_op(input logic [7:0] a, input logic [7:0] exp, input logic exp_hit, input string name);
    rd_q.push_back(exp);
    cpu_op(1'b1, 1'b0, a, 8'h00, exp_hit, name);
  endtask

  task automatic mem_exp(input logic w, input logic [5:0] a, input logic [31:0] d);
    mem_q.push_back('{wr: w, addr: a, dat: d});
  endtask

  initial begin
    rst_n = 1'b1; rd = 1'b0; wr = 1'b0; addr = 8'h00; wdata = 8'h00;

    // Reset state and cold read
    apply_reset();
    #1;
    chk("rst_busywait", 32'(busywait), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    chk("rst_readdata", 32'(readdata), 32'd0);
    mem_exp(1'b0, 6'h00, 32'h0);
    rd_op(8'h00, 8'h11, 1'b0, "cold_rd00");
    chk("cold_miss_count", 32'(miss_count), 32'd1);
    chk("cold_hit_count", 32'(hit_count), 32'd0);
    rd_op(8'h03, 8'h44, 1'b1, "cold_rd03");
    chk("cold_hit_count2", 32'(hit_count), 32'd1);

    // Associativity and LRU
    apply_reset();
    mem_exp(1'b0, 6'h00, 32'h0);
    rd_op(8'h00, 8'h11, 1'b0, "lru_rd00");
    mem_exp(1'b0, 6'h04, 32'h0);
    rd_op(8'h10, 8'h55, 1'b0, "lru_rd10");
    rd_op(8'h00, 8'h11, 1'b1, "lru_rd00_hit");
    mem_exp(1'b0, 6'h08, 32'h0);
    rd_op(8'h20, 8'h99, 1'b0, "lru_rd20");
    rd_op(8'h00, 8'h11, 1'b1, "lru_rd00_keep");
    chk("lru_miss_count", 32'(miss_count), 32'd3);
    chk("lru_hit_count", 32'(hit_count), 32'd2);

    // Dirty eviction
    apply_reset();
    mem_exp(1'b0, 6'h00, 32'h0);
    cpu_op(1'b0, 1'b1, 8'h01, 8'hAB, 1'b0, "dirty_wr01");
    mem_exp(1'b0, 6'h04, 32'h0);
    rd_op(8'h10, 8'h55, 1'b0, "dirty_rd10");
    rd_op(8'h10, 8'h55, 1'b1, "dirty_rd10_hit");
    mem_exp(1'b1, 6'h00, 32'h4433AB11);
    mem_exp(1'b0, 6'h08, 32'h0);
    rd_op(8'h20, 8'h99, 1'b0, "dirty_rd20");
    mem_exp(1'b0, 6'h00, 32'h0);
    rd_op(8'h01, 8'hAB, 1'b0, "dirty_rd01");
    chk("dirty_miss_count", 32'(miss_count), 32'd4);
    chk("dirty_hit_count", 32'(hit_count), 32'd1);

    // Reset in the middle of a fetch
    apply_reset();
    mem_exp(1'b0, 6'h00, 32'h0);
    @(posedge clk);
    #1;
    rd = 1'b1; addr = 8'h00;
    for (int i = 0; i < 50 && !mem_read; i++) @(negedge clk);
    chk("abort_mem_read_up", 32'(mem_read), 32'd1);
    chk("abort_miss_before", 32'(miss_count), 32'd1);
    #2;
    rst_n = 1'b0;
    rd = 1'b0;
    #1;
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_busywait", 32'(busywait), 32'd0);
    chk("abort_miss_count", 32'(miss_count), 32'd0);
    chk("abort_hit_count", 32'(hit_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_exp(1'b0, 6'h00, 32'h0);
    rd_op(8'h00, 8'h11, 1'b0, "abort_rd00");
    chk("abort_miss_after", 32'(miss_count), 32'd1);

    // Hit counter saturation
    apply_reset();
    mem_exp(1'b0, 6'h00, 32'h0);
    rd_op(8'h00, 8'h11, 1'b0, "sat_fill");
    for (int i = 1; i <= 20; i++) begin
      rd_op(8'h00, 8'h11, 1'b1, "sat_rd00");
      chk("sat_hit_count", 32'(hit_count), (i > 15) ? 32'd15 : 32'(i));
    end

    // READ and WRITE together store to a resident word
    cpu_op(1'b1, 1'b1, 8'h02, 8'h5A, 1'b1, "rw_wr02");
    rd_op(8'h02, 8'h5A, 1'b1, "rw_rd02");
    mem_exp(1'b0, 6'h04, 32'h0);
    rd_op(8'h10, 8'h55, 1'b0, "rw_rd10");
    mem_exp(1'b1, 6'h00, 32'h445A2211);
    mem_exp(1'b0, 6'h08, 32'h0);
    rd_op(8'h20, 8'h99, 1'b0, "rw_rd20");

    repeat (5) @(negedge clk);
    chk("load_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
